// File: rtl/ddr_test_sequencer.sv
// rtl/ddr_test_sequencer.sv - autonomous four-pass DDR tester sequencer over an AXI-Lite config write port
module ddr_test_sequencer #(
    parameter logic [31:0] DDR_SIZE       = 32'd134217728,
    parameter int          BURST_LEN      = 16,
    parameter int unsigned START_DELAY    = 100,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFFFFF0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        cfg_awvalid_o,
    output logic [31:0] cfg_awaddr_o,
    input  logic        cfg_awready_i,
    output logic        cfg_wvalid_o,
    output logic [31:0] cfg_wdata_o,
    output logic [3:0]  cfg_wstrb_o,
    input  logic        cfg_wready_i,
    input  logic        cfg_bvalid_i,
    input  logic [1:0]  cfg_bresp_i,
    output logic        cfg_bready_o,
    input  logic        status_busy_i,
    input  logic        status_err_i,
    output logic [1:0]  step_o,
    output logic        done_o,
    output logic        fail_o,
    output logic [1:0]  fail_code_o,
    output logic        rgb_led_r_o,
    output logic        rgb_led_g_o,
    output logic        rgb_led_b_o
);

    typedef enum logic [3:0] {
        S_DELAY, S_WR_END, S_WR_CFG, S_RESP, S_SETTLE,
        S_WAIT_DONE, S_NEXT, S_PASS, S_FAIL
    } state_t;

    localparam logic [3:0]  BURST_FIELD  = 4'(BURST_LEN / 4 - 1);
    localparam logic [31:0] ADDR_CFG     = 32'h0000_0000;
    localparam logic [31:0] ADDR_END     = 32'h0000_0008;
    localparam logic [31:0] CFG_ONES     = 32'h0000_0002;
    localparam logic [31:0] CFG_INCR     = 32'h0000_0004;
    localparam logic [31:0] CFG_READ     = 32'h0000_0100;
    localparam logic [31:0] DELAY_LAST   = 32'(START_DELAY - 1);
    localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

    state_t      state;
    logic [31:0] cnt;
    logic        issued;
    logic        aw_done;
    logic        w_done;
    logic        end_write;
    logic [31:0] cfg_word;
    logic        aw_ok;
    logic        w_ok;

    always_comb begin
        cfg_word = {BURST_FIELD, 28'h0};
        case (step_o)
            2'd0:    cfg_word = cfg_word | CFG_INCR;
            2'd1:    cfg_word = cfg_word | CFG_INCR | CFG_READ;
            2'd2:    cfg_word = cfg_word | CFG_ONES;
            default: cfg_word = cfg_word | CFG_ONES | CFG_READ;
        endcase
    end

    // A channel counts as accepted if it handshook earlier or is handshaking now
    assign aw_ok = aw_done | (cfg_awvalid_o & cfg_awready_i);
    assign w_ok  = w_done  | (cfg_wvalid_o  & cfg_wready_i);

    assign cfg_wstrb_o  = 4'hF;
    assign cfg_bready_o = 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= S_DELAY;
            cnt           <= 32'd0;
            issued        <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            end_write     <= 1'b0;
            cfg_awvalid_o <= 1'b0;
            cfg_awaddr_o  <= 32'd0;
            cfg_wvalid_o  <= 1'b0;
            cfg_wdata_o   <= 32'd0;
            step_o        <= 2'd0;
            done_o        <= 1'b0;
            fail_o        <= 1'b0;
            fail_code_o   <= 2'd0;
            rgb_led_r_o   <= 1'b1;
            rgb_led_g_o   <= 1'b1;
            rgb_led_b_o   <= 1'b0;
        end else begin
            rgb_led_r_o <= (state != S_FAIL);
            rgb_led_g_o <= (state != S_PASS);
            rgb_led_b_o <= (state == S_PASS) || (state == S_FAIL);

            case (state)
                S_DELAY: begin
                    if (cnt == DELAY_LAST) begin
                        cnt   <= 32'd0;
                        state <= S_WR_END;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                S_WR_END, S_WR_CFG: begin
                    if (!issued) begin
                        issued        <= 1'b1;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        end_write     <= (state == S_WR_END);
                        cfg_awvalid_o <= 1'b1;
                        cfg_wvalid_o  <= 1'b1;
                        cfg_awaddr_o  <= (state == S_WR_END) ? ADDR_END : ADDR_CFG;
                        cfg_wdata_o   <= (state == S_WR_END) ? DDR_SIZE : cfg_word;
                    end else begin
                        if (cfg_awvalid_o && cfg_awready_i) begin
                            cfg_awvalid_o <= 1'b0;
                            aw_done       <= 1'b1;
                        end
                        if (cfg_wvalid_o && cfg_wready_i) begin
                            cfg_wvalid_o <= 1'b0;
                            w_done       <= 1'b1;
                        end
                        if (aw_ok && w_ok) begin
                            issued <= 1'b0;
                            state  <= S_RESP;
                        end
                    end
                end

                S_RESP: begin
                    if (cfg_bvalid_i) begin
                        if (cfg_bresp_i != 2'b00) begin
                            state       <= S_FAIL;
                            done_o      <= 1'b1;
                            fail_o      <= 1'b1;
                            fail_code_o <= 2'd1;
                        end else if (end_write) begin
                            state <= S_WR_CFG;
                        end else begin
                            cnt   <= 32'd0;
                            state <= S_SETTLE;
                        end
                    end
                end

                // Gives the tester time to raise busy before it is trusted
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= 32'd0;
                        state <= S_WAIT_DONE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                S_WAIT_DONE: begin
                    if (status_err_i) begin
                        state       <= S_FAIL;
                        done_o      <= 1'b1;
                        fail_o      <= 1'b1;
                        fail_code_o <= 2'd0;
                    end else if (!status_busy_i) begin
                        state <= S_NEXT;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state       <= S_FAIL;
                        done_o      <= 1'b1;
                        fail_o      <= 1'b1;
                        fail_code_o <= 2'd2;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                S_NEXT: begin
                    if (step_o == 2'd3) begin
                        state  <= S_PASS;
                        done_o <= 1'b1;
                    end else begin
                        step_o <= step_o + 2'd1;
                        state  <= S_WR_CFG;
                    end
                end

                S_PASS, S_FAIL: begin
                end

                default: state <= S_DELAY;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_test_sequencer.sv
// tb/tb_ddr_test_sequencer.sv - scoreboard bench: tester model drives responses, monitor checks config writes
module tb_ddr_test_sequencer;

    localparam int unsigned START_DELAY = 100;
    localparam int unsigned SETTLE      = 4;
    localparam int unsigned TIMEOUT     = 1000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid;
    logic [31:0] awaddr;
    logic        awready = 1'b0;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wready = 1'b0;
    logic        bvalid = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bready;
    logic        busy = 1'b0;
    logic        err = 1'b0;
    logic [1:0]  step;
    logic        done;
    logic        fail;
    logic [1:0]  fail_code;
    logic        led_r, led_g, led_b;

    ddr_test_sequencer #(
        .START_DELAY   (START_DELAY),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(32'(TIMEOUT))
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_awvalid_o(awvalid),
        .cfg_awaddr_o (awaddr),
        .cfg_awready_i(awready),
        .cfg_wvalid_o (wvalid),
        .cfg_wdata_o  (wdata),
        .cfg_wstrb_o  (wstrb),
        .cfg_wready_i (wready),
        .cfg_bvalid_i (bvalid),
        .cfg_bresp_i  (bresp),
        .cfg_bready_o (bready),
        .status_busy_i(busy),
        .status_err_i (err),
        .step_o       (step),
        .done_o       (done),
        .fail_o       (fail),
        .fail_code_o  (fail_code),
        .rgb_led_r_o  (led_r),
        .rgb_led_g_o  (led_g),
        .rgb_led_b_o  (led_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Tester model knobs, indexed by write number (0 = END write, 1..4 = CFG steps 0..3)
    int aw_lat[8];
    int w_lat[8];
    int bresp_at, err_at, hang_at;

    int   widx, aw_cnt, w_cnt, busy_cnt, b_cyc;
    logic aw_got, w_got, hs_aw, hs_w, hang, err_arm;

    task automatic clear_knobs();
        for (int i = 0; i < 8; i++) begin
            aw_lat[i] = 0;
            w_lat[i]  = 0;
        end
        bresp_at = -1;
        err_at   = -1;
        hang_at  = -1;
    endtask

    initial begin
        b_cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                widx = 0; aw_cnt = 0; w_cnt = 0; busy_cnt = 0;
                aw_got = 0; w_got = 0; hs_aw = 0; hs_w = 0; hang = 0; err_arm = 0;
                awready = 0; wready = 0; bvalid = 0; bresp = 0; busy = 0; err = 0;
            end else begin
                if (hs_aw) aw_got = 1;
                if (hs_w)  w_got  = 1;
                if (bvalid) begin
                    bvalid = 0;
                    bresp  = 0;
                    b_cyc  = cyc;
                    widx++;
                end
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0 && err_arm) err = 1;
                end
                if (aw_got && w_got) begin
                    bvalid = 1;
                    bresp  = (widx == bresp_at) ? 2'b10 : 2'b00;
                    aw_got = 0;
                    w_got  = 0;
                    if (widx > 0) begin
                        busy_cnt = 50;
                        if (widx == err_at)  err_arm = 1;
                        if (widx == hang_at) hang = 1;
                    end
                end
                busy    = hang || (busy_cnt > 0);
                awready = awvalid && (aw_cnt >= aw_lat[widx % 8]);
                aw_cnt  = awvalid ? aw_cnt + 1 : 0;
                wready  = wvalid && (w_cnt >= w_lat[widx % 8]);
                w_cnt   = wvalid ? w_cnt + 1 : 0;
                hs_aw   = awvalid && awready;
                hs_w    = wvalid && wready;
            end
        end
    end

    wr_t         exp_q[$];
    logic [31:0] got_a[$];
    logic [31:0] got_d[$];
    wr_t         exp_tab[5];

    // Monitor: handshake capture, scoreboard compare and channel stability
    initial begin
        logic        pv_aw, pv_w, ph_aw, ph_w;
        logic [31:0] pa, pd, a, d;
        wr_t         e;
        pv_aw = 0; pv_w = 0; ph_aw = 0; ph_w = 0; pa = 0; pd = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                got_a.delete();
                got_d.delete();
                pv_aw = 0; pv_w = 0; ph_aw = 0; ph_w = 0;
            end else begin
                if (ph_aw) chk("aw_drop_after_hs", awvalid, 0);
                else if (pv_aw) begin
                    chk("aw_hold_valid", awvalid, 1);
                    chk("aw_hold_addr", awaddr, pa);
                end
                if (ph_w) chk("w_drop_after_hs", wvalid, 0);
                else if (pv_w) begin
                    chk("w_hold_valid", wvalid, 1);
                    chk("w_hold_data", wdata, pd);
                end
                if (awvalid && awready) got_a.push_back(awaddr);
                if (wvalid && wready)   got_d.push_back(wdata);
                while (got_a.size() > 0 && got_d.size() > 0) begin
                    a = got_a.pop_front();
                    d = got_d.pop_front();
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write actual=%0h/%0h required=none", a, d);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", a, e.addr);
                        chk("wr_data", d, e.data);
                    end
                end
                pv_aw = awvalid; ph_aw = awvalid && awready; pa = awaddr;
                pv_w  = wvalid;  ph_w  = wvalid && wready;   pd = wdata;
            end
        end
    end

    task automatic push_writes(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_tab[i]);
    endtask

    task automatic start_case(input int n);
        rst = 1;
        repeat (3) @(negedge clk);
        exp_q.delete();
        push_writes(n);
        rst = 0;
    endtask

    task automatic check_start_delay();
        int n;
        n = 0;
        while (!awvalid && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("start_delay_cycles", n, START_DELAY + 1);
    endtask

    task automatic wait_done(output int dcyc);
        int n;
        n = 0;
        while (!done && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) chk("done_timeout", done, 1);
        dcyc = cyc;
    endtask

    task automatic check_end(input logic f, input logic [1:0] code, input logic [1:0] st);
        int av;
        chk("done", done, 1);
        chk("fail", fail, f);
        chk("fail_code", fail_code, code);
        chk("step", step, st);
        repeat (2) @(negedge clk);
        chk("led_r", led_r, f ? 0 : 1);
        chk("led_g", led_g, f ? 1 : 0);
        chk("led_b", led_b, 1);
        av = 0;
        repeat (50) begin
            @(negedge clk);
            if (awvalid) av++;
        end
        chk("no_awvalid_after_done", av, 0);
        chk("writes_outstanding", exp_q.size(), 0);
    endtask

    initial begin
        int dcyc, n;
        exp_tab = '{'{32'h8, 32'h0800_0000}, '{32'h0, 32'h3000_0004},
                    '{32'h0, 32'h3000_0104}, '{32'h0, 32'h3000_0002},
                    '{32'h0, 32'h3000_0102}};
        clear_knobs();

        rst = 1;
        repeat (3) @(negedge clk);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_step", step, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_fail_code", fail_code, 0);
        chk("rst_led", {led_r, led_g, led_b}, 3'b110);
        chk("wstrb", wstrb, 4'hF);
        chk("bready", bready, 1);

        // Ideal tester, full pass
        start_case(5);
        check_start_delay();
        wait_done(dcyc);
        check_end(0, 2'd0, 2'd3);

        // Address accepted 3 cycles ahead of data on the END write
        clear_knobs();
        w_lat[0] = 3;
        start_case(5);
        wait_done(dcyc);
        check_end(0, 2'd0, 2'd3);

        // Error response on step-1 CFG write
        clear_knobs();
        bresp_at = 2;
        start_case(3);
        wait_done(dcyc);
        check_end(1, 2'd1, 2'd1);

        // Tester error coincident with busy falling in step 2
        clear_knobs();
        err_at = 3;
        start_case(4);
        wait_done(dcyc);
        check_end(1, 2'd0, 2'd2);

        // Busy stuck high during step 0
        clear_knobs();
        hang_at = 1;
        start_case(2);
        wait_done(dcyc);
        chk("timeout_latency", dcyc - b_cyc, SETTLE + TIMEOUT);
        check_end(1, 2'd2, 2'd0);

        // Reset while the step-3 address is pending
        clear_knobs();
        aw_lat[4] = 1000000;
        w_lat[4]  = 1000000;
        start_case(4);
        n = 0;
        while (!(widx == 4 && awvalid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("step3_awvalid_seen", awvalid, 1);
        #2;
        rst = 1;
        #1;
        chk("async_awvalid", awvalid, 0);
        chk("async_wvalid", wvalid, 0);
        chk("async_awaddr", awaddr, 0);
        chk("async_wdata", wdata, 0);
        chk("async_step", step, 0);
        chk("async_done_fail", {done, fail}, 2'b00);
        chk("async_led", {led_r, led_g, led_b}, 3'b110);
        chk("pre_reset_writes", exp_q.size(), 0);
        clear_knobs();
        start_case(5);
        check_start_delay();
        wait_done(dcyc);
        check_end(0, 2'd0, 2'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
